// File: rtl/regs_wb_arbiter.sv
// regs_wb_arbiter
// Shares the register file's single write port between two write-back
// requesters: A (ALU result) and B (memory load result). Each requester
// has a valid/ready channel feeding a one-entry buffer, and a round-robin
// arbiter with same-address age ordering drives a registered write port.
// A pending-write bitmap is exported for hazard detection.
//
// Optional feature: define WB_ARB_FWD_EN to add the fwd_addr/fwd_hit/
// fwd_data lookup used for decode-stage forwarding.

module regs_wb_arbiter #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [AW-1:0]        a_addr,
  input  logic [DW-1:0]        a_data,
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [AW-1:0]        b_addr,
  input  logic [DW-1:0]        b_data,
  output logic                 wt_en,
  output logic [AW-1:0]        wt_addr,
  output logic [DW-1:0]        wt_data,
  output logic [(2**AW)-1:0]   pend_mask
`ifdef WB_ARB_FWD_EN
  ,
  input  logic [AW-1:0]        fwd_addr,
  output logic                 fwd_hit,
  output logic [DW-1:0]        fwd_data
`endif
);

  typedef enum logic {
    CH_A = 1'b0,
    CH_B = 1'b1
  } chan_t;

  logic          bufa_v;
  logic [AW-1:0] bufa_addr;
  logic [DW-1:0] bufa_data;
  logic          bufb_v;
  logic [AW-1:0] bufb_addr;
  logic [DW-1:0] bufb_data;

  chan_t rr_last;
  chan_t older;
  chan_t older_n;

  logic grant_a;
  logic grant_b;
  logic load_a;
  logic load_b;
  logic keep_a;
  logic keep_b;
  logic same_addr;

  assign same_addr = (bufa_addr == bufb_addr);

  // Pick the buffer that drives the write port next, from registered state only
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (bufa_v && bufb_v) begin
      if (same_addr) begin
        grant_a = (older == CH_A);
      end else begin
        grant_a = (rr_last == CH_B);
      end
      grant_b = ~grant_a;
    end else begin
      grant_a = bufa_v;
      grant_b = bufb_v;
    end
  end

  // A buffer can take a new entry when empty or when it is draining this cycle
  assign a_ready = ~bufa_v | grant_a;
  assign b_ready = ~bufb_v | grant_b;

  // Writes to register 0 complete the handshake but are never stored
  assign load_a = a_valid & a_ready & (a_addr != '0);
  assign load_b = b_valid & b_ready & (b_addr != '0);

  assign keep_a = bufa_v & ~grant_a;
  assign keep_b = bufb_v & ~grant_b;

  // Buffer A: refill takes priority over the free that a grant would cause
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bufa_v    <= 1'b0;
      bufa_addr <= '0;
      bufa_data <= '0;
    end else if (load_a) begin
      bufa_v    <= 1'b1;
      bufa_addr <= a_addr;
      bufa_data <= a_data;
    end else if (grant_a) begin
      bufa_v    <= 1'b0;
    end
  end

  // Buffer B: same behaviour as buffer A
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bufb_v    <= 1'b0;
      bufb_addr <= '0;
      bufb_data <= '0;
    end else if (load_b) begin
      bufb_v    <= 1'b1;
      bufb_addr <= b_addr;
      bufb_data <= b_data;
    end else if (grant_b) begin
      bufb_v    <= 1'b0;
    end
  end

  // Registered write port: one strobe per granted entry, address/data hold otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wt_en   <= 1'b0;
      wt_addr <= '0;
      wt_data <= '0;
    end else if (grant_a) begin
      wt_en   <= 1'b1;
      wt_addr <= bufa_addr;
      wt_data <= bufa_data;
    end else if (grant_b) begin
      wt_en   <= 1'b1;
      wt_addr <= bufb_addr;
      wt_data <= bufb_data;
    end else begin
      wt_en   <= 1'b0;
    end
  end

  // Work out which buffer will hold the earlier-accepted entry after this edge
  always_comb begin
    older_n = older;
    if (load_a && load_b) begin
      older_n = CH_A;
    end else if (load_a) begin
      older_n = keep_b ? CH_B : CH_A;
    end else if (load_b) begin
      older_n = keep_a ? CH_A : CH_B;
    end else if (keep_a && !keep_b) begin
      older_n = CH_A;
    end else if (keep_b && !keep_a) begin
      older_n = CH_B;
    end
  end

  // Round-robin pointer and age flag; rr_last starts at B so A wins first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last <= CH_B;
      older   <= CH_A;
    end else begin
      older <= older_n;
      if (grant_a) begin
        rr_last <= CH_A;
      end else if (grant_b) begin
        rr_last <= CH_B;
      end
    end
  end

  // Every register with a write still buffered or on the port; r0 never pends
  always_comb begin
    pend_mask = '0;
    if (bufa_v) begin
      pend_mask[bufa_addr] = 1'b1;
    end
    if (bufb_v) begin
      pend_mask[bufb_addr] = 1'b1;
    end
    if (wt_en) begin
      pend_mask[wt_addr] = 1'b1;
    end
    pend_mask[0] = 1'b0;
  end

`ifdef WB_ARB_FWD_EN
  logic hit_a;
  logic hit_b;
  logic hit_w;

  assign hit_a = bufa_v & (bufa_addr == fwd_addr);
  assign hit_b = bufb_v & (bufb_addr == fwd_addr);
  assign hit_w = wt_en  & (wt_addr   == fwd_addr);

  // Forward the youngest pending value: younger buffer, older buffer, then port
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (fwd_addr != '0) begin
      if (older == CH_A) begin
        if (hit_b) begin
          fwd_hit  = 1'b1;
          fwd_data = bufb_data;
        end else if (hit_a) begin
          fwd_hit  = 1'b1;
          fwd_data = bufa_data;
        end else if (hit_w) begin
          fwd_hit  = 1'b1;
          fwd_data = wt_data;
        end
      end else begin
        if (hit_a) begin
          fwd_hit  = 1'b1;
          fwd_data = bufa_data;
        end else if (hit_b) begin
          fwd_hit  = 1'b1;
          fwd_data = bufb_data;
        end else if (hit_w) begin
          fwd_hit  = 1'b1;
          fwd_data = wt_data;
        end
      end
    end
  end
`else
  // Forwarding disabled: no lookup ports and no address comparators
`endif

endmodule

// File: tb/tb_regs_wb_arbiter.sv
// tb_regs_wb_arbiter
// Directed scenarios plus a randomized run checked against a transaction
// model: per-channel entry queues tagged with acceptance order, and the
// arbitration rules (lone entry, same address -> earlier accepted,
// otherwise the channel not granted last). Define WB_ARB_FWD_EN to also
// exercise the forwarding lookup.

module tb_regs_wb_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_valid = 1'b0;
  logic          a_ready;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_data = '0;
  logic          b_valid = 1'b0;
  logic          b_ready;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_data = '0;
  logic          wt_en;
  logic [AW-1:0] wt_addr;
  logic [DW-1:0] wt_data;
  logic [31:0]   pend_mask;
`ifdef WB_ARB_FWD_EN
  logic [AW-1:0] fwd_addr = '0;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
`endif

  int total = 0;
  int bad   = 0;

  regs_wb_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_addr    (a_addr),
    .a_data    (a_data),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_addr    (b_addr),
    .b_data    (b_data),
    .wt_en     (wt_en),
    .wt_addr   (wt_addr),
    .wt_data   (wt_data),
    .pend_mask (pend_mask)
`ifdef WB_ARB_FWD_EN
    ,
    .fwd_addr  (fwd_addr),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            seq;
  } ent_t;

  ent_t          qa[$];
  ent_t          qb[$];
  int            m_last;
  logic          m_wt_en;
  logic [AW-1:0] m_wt_addr;
  logic [DW-1:0] m_wt_data;
  int            m_seq;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    a_valid = 1'b0;
    b_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // 0 = nothing, 1 = A, 2 = B
  function automatic int model_grant();
    if (qa.size() != 0 && qb.size() == 0) return 1;
    if (qa.size() == 0 && qb.size() != 0) return 2;
    if (qa.size() != 0 && qb.size() != 0) begin
      if (qa[0].addr == qb[0].addr) return (qa[0].seq < qb[0].seq) ? 1 : 2;
      return (m_last == 1) ? 2 : 1;
    end
    return 0;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    tick();
    total++; if (wt_en !== 1'b0) begin bad++; $display("[TB] FAIL reset_wt_en: got %b expected 0", wt_en); end
    total++; if (wt_addr !== '0) begin bad++; $display("[TB] FAIL reset_wt_addr: got %0d expected 0", wt_addr); end
    total++; if (wt_data !== '0) begin bad++; $display("[TB] FAIL reset_wt_data: got %h expected 0", wt_data); end
    total++; if (pend_mask !== 32'h0) begin bad++; $display("[TB] FAIL reset_pend_mask: got %h expected 0", pend_mask); end
    total++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready: got a=%b b=%b expected 1 1", a_ready, b_ready); end
    rst = 1'b0;
    a_valid = 1'b1; a_addr = 5'd10; a_data = 32'h5;
    b_valid = 1'b1; b_addr = 5'd11; b_data = 32'h6;
    tick();
    a_valid = 1'b0;
    b_valid = 1'b0;
    total++; if (pend_mask !== 32'h0000_0C00) begin bad++; $display("[TB] FAIL reset_fill_mask: got %h expected 00000c00", pend_mask); end
    #2 rst = 1'b1;
    #1;
    total++; if (wt_en !== 1'b0 || pend_mask !== 32'h0) begin bad++; $display("[TB] FAIL reset_mid_clear: got en=%b mask=%h expected 0 0", wt_en, pend_mask); end
    total++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_mid_ready: got a=%b b=%b expected 1 1", a_ready, b_ready); end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (wt_en !== 1'b0 || pend_mask !== 32'h0) begin bad++; $display("[TB] FAIL reset_discard: cycle %0d got en=%b addr=%0d mask=%h expected 0", i, wt_en, wt_addr, pend_mask); end
    end
  endtask

  task automatic test_lone_channel();
    logic [AW-1:0] addrs [3];
    logic [DW-1:0] datas [3];
    addrs[0] = 5'd3; datas[0] = 32'h11;
    addrs[1] = 5'd4; datas[1] = 32'h22;
    addrs[2] = 5'd5; datas[2] = 32'h33;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i < 3) begin
        a_valid = 1'b1; a_addr = addrs[i]; a_data = datas[i];
        total++; if (a_ready !== 1'b1) begin bad++; $display("[TB] FAIL lone_ready: step %0d got %b expected 1", i, a_ready); end
      end else begin
        a_valid = 1'b0;
      end
      tick();
      if (i >= 1 && i <= 3) begin
        total++;
        if (wt_en !== 1'b1 || wt_addr !== addrs[i-1] || wt_data !== datas[i-1]) begin
          bad++; $display("[TB] FAIL lone_port: step %0d got en=%b (%0d,%h) expected 1 (%0d,%h)", i, wt_en, wt_addr, wt_data, addrs[i-1], datas[i-1]);
        end
      end else if (i == 4) begin
        total++; if (wt_en !== 1'b0) begin bad++; $display("[TB] FAIL lone_idle: got en=%b expected 0", wt_en); end
      end
    end
  endtask

  task automatic test_contention();
    do_reset();
    a_valid = 1'b1; a_addr = 5'd1; a_data = 32'hA;
    b_valid = 1'b1; b_addr = 5'd2; b_data = 32'hB;
    tick();
    a_valid = 1'b0;
    b_valid = 1'b0;
    total++; if (wt_en !== 1'b0 || pend_mask !== 32'h6) begin bad++; $display("[TB] FAIL cont_loaded: got en=%b mask=%h expected 0 00000006", wt_en, pend_mask); end
    total++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin bad++; $display("[TB] FAIL cont_ready1: got a=%b b=%b expected 1 0", a_ready, b_ready); end
    tick();
    total++; if (wt_en !== 1'b1 || wt_addr !== 5'd1 || wt_data !== 32'hA) begin bad++; $display("[TB] FAIL cont_first: got en=%b (%0d,%h) expected 1 (1,a)", wt_en, wt_addr, wt_data); end
    total++; if (b_ready !== 1'b1) begin bad++; $display("[TB] FAIL cont_ready2: got b=%b expected 1", b_ready); end
    tick();
    total++; if (wt_en !== 1'b1 || wt_addr !== 5'd2 || wt_data !== 32'hB) begin bad++; $display("[TB] FAIL cont_second: got en=%b (%0d,%h) expected 1 (2,b)", wt_en, wt_addr, wt_data); end
    tick();
    total++; if (wt_en !== 1'b0 || wt_addr !== 5'd2) begin bad++; $display("[TB] FAIL cont_hold: got en=%b addr=%0d expected 0 2", wt_en, wt_addr); end
  endtask

  task automatic test_same_address();
    do_reset();
    a_valid = 1'b1; a_addr = 5'd6; a_data = 32'h66;
    b_valid = 1'b1; b_addr = 5'd7; b_data = 32'hBBBB;
    tick();
    a_addr = 5'd7; a_data = 32'hAAAA;
    b_valid = 1'b0;
    total++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin bad++; $display("[TB] FAIL same_ready: got a=%b b=%b expected 1 0", a_ready, b_ready); end
    tick();
    a_valid = 1'b0;
    total++; if (wt_en !== 1'b1 || wt_addr !== 5'd6 || wt_data !== 32'h66) begin bad++; $display("[TB] FAIL same_first: got en=%b (%0d,%h) expected 1 (6,66)", wt_en, wt_addr, wt_data); end
    total++; if (pend_mask !== 32'hC0) begin bad++; $display("[TB] FAIL same_mask: got %h expected 000000c0", pend_mask); end
    tick();
    total++; if (wt_en !== 1'b1 || wt_addr !== 5'd7 || wt_data !== 32'hBBBB) begin bad++; $display("[TB] FAIL same_order1: got en=%b (%0d,%h) expected 1 (7,bbbb)", wt_en, wt_addr, wt_data); end
    tick();
    total++; if (wt_en !== 1'b1 || wt_addr !== 5'd7 || wt_data !== 32'hAAAA) begin bad++; $display("[TB] FAIL same_order2: got en=%b (%0d,%h) expected 1 (7,aaaa)", wt_en, wt_addr, wt_data); end
    tick();
    total++; if (wt_en !== 1'b0 || pend_mask !== 32'h0) begin bad++; $display("[TB] FAIL same_drain: got en=%b mask=%h expected 0 0", wt_en, pend_mask); end
  endtask

  task automatic test_addr_zero();
    do_reset();
    a_valid = 1'b1; a_addr = 5'd0; a_data = 32'hFFFF_FFFF;
    total++; if (a_ready !== 1'b1) begin bad++; $display("[TB] FAIL zero_ready: got %b expected 1", a_ready); end
    tick();
    a_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++; if (wt_en !== 1'b0 || pend_mask !== 32'h0 || a_ready !== 1'b1) begin bad++; $display("[TB] FAIL zero_dropped: cycle %0d got en=%b mask=%h ready=%b expected 0 0 1", i, wt_en, pend_mask, a_ready); end
      tick();
    end
  endtask

`ifdef WB_ARB_FWD_EN
  task automatic test_forward();
    do_reset();
    a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h1234;
    tick();
    a_valid = 1'b0;
    fwd_addr = 5'd9;
    #1;
    total++; if (fwd_hit !== 1'b1 || fwd_data !== 32'h1234) begin bad++; $display("[TB] FAIL fwd_hit: got %b %h expected 1 1234", fwd_hit, fwd_data); end
    fwd_addr = 5'd0;
    #1;
    total++; if (fwd_hit !== 1'b0 || fwd_data !== 32'h0) begin bad++; $display("[TB] FAIL fwd_zero: got %b %h expected 0 0", fwd_hit, fwd_data); end
    fwd_addr = 5'd4;
    #1;
    total++; if (fwd_hit !== 1'b0) begin bad++; $display("[TB] FAIL fwd_miss: got %b expected 0", fwd_hit); end
    tick();
  endtask
`endif

  task automatic test_random();
    int   g;
    logic ea;
    logic eb;
    logic [31:0] exp_pm;
    ent_t e;
    do_reset();
    qa.delete();
    qb.delete();
    m_last    = 2;
    m_wt_en   = 1'b0;
    m_wt_addr = '0;
    m_wt_data = '0;
    m_seq     = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      a_valid = (cyc < 390) && ($urandom_range(0, 3) != 0);
      a_addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 3));
      a_data  = $urandom;
      b_valid = (cyc < 390) && ($urandom_range(0, 3) != 0);
      b_addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 3));
      b_data  = $urandom;
`ifdef WB_ARB_FWD_EN
      fwd_addr = 5'($urandom_range(0, 3));
`endif
      #1;
      g  = model_grant();
      ea = (qa.size() == 0) || (g == 1);
      eb = (qb.size() == 0) || (g == 2);
      exp_pm = 32'h0;
      foreach (qa[k]) exp_pm = exp_pm | (32'h1 << qa[k].addr);
      foreach (qb[k]) exp_pm = exp_pm | (32'h1 << qb[k].addr);
      if (m_wt_en) exp_pm = exp_pm | (32'h1 << m_wt_addr);
      exp_pm = exp_pm & 32'hFFFF_FFFE;
      total++; if (a_ready !== ea || b_ready !== eb) begin bad++; $display("[TB] FAIL rand_ready: cycle %0d got a=%b b=%b expected %b %b", cyc, a_ready, b_ready, ea, eb); end
      total++; if (pend_mask !== exp_pm) begin bad++; $display("[TB] FAIL rand_mask: cycle %0d got %h expected %h", cyc, pend_mask, exp_pm); end
`ifdef WB_ARB_FWD_EN
      begin
        logic          eh;
        logic [DW-1:0] ed;
        int            best;
        eh = 1'b0; ed = '0; best = -1;
        if (fwd_addr != 5'd0) begin
          if (qa.size() != 0 && qa[0].addr == fwd_addr && qa[0].seq > best) begin eh = 1'b1; ed = qa[0].data; best = qa[0].seq; end
          if (qb.size() != 0 && qb[0].addr == fwd_addr && qb[0].seq > best) begin eh = 1'b1; ed = qb[0].data; best = qb[0].seq; end
          if (!eh && m_wt_en && m_wt_addr == fwd_addr) begin eh = 1'b1; ed = m_wt_data; end
        end
        total++; if (fwd_hit !== eh || fwd_data !== ed) begin bad++; $display("[TB] FAIL rand_fwd: cycle %0d got %b %h expected %b %h", cyc, fwd_hit, fwd_data, eh, ed); end
      end
`endif
      @(posedge clk);
      if (g == 1) begin
        m_wt_en = 1'b1; m_wt_addr = qa[0].addr; m_wt_data = qa[0].data;
        void'(qa.pop_front());
        m_last = 1;
      end else if (g == 2) begin
        m_wt_en = 1'b1; m_wt_addr = qb[0].addr; m_wt_data = qb[0].data;
        void'(qb.pop_front());
        m_last = 2;
      end else begin
        m_wt_en = 1'b0;
      end
      if (a_valid && ea && a_addr != 5'd0) begin
        e.addr = a_addr; e.data = a_data; e.seq = m_seq;
        qa.push_back(e);
        m_seq++;
      end
      if (b_valid && eb && b_addr != 5'd0) begin
        e.addr = b_addr; e.data = b_data; e.seq = m_seq;
        qb.push_back(e);
        m_seq++;
      end
      #1;
      total++;
      if (wt_en !== m_wt_en || wt_addr !== m_wt_addr || wt_data !== m_wt_data) begin
        bad++; $display("[TB] FAIL rand_port: cycle %0d got en=%b (%0d,%h) expected %b (%0d,%h)", cyc, wt_en, wt_addr, wt_data, m_wt_en, m_wt_addr, m_wt_data);
      end
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  initial begin
    $display("[TB] starting regs_wb_arbiter bench");
    test_reset();
    test_lone_channel();
    test_contention();
    test_same_address();
    test_addr_zero();
`ifdef WB_ARB_FWD_EN
    test_forward();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
